// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Purpose:
//   Round-robin arbiter and access sequencer that shares one single-port
//   Memory (combinational read, clocked write, tri-state data bus) among NREQ
//   requesters. Each granted access drives the Memory's re/we/addr and the
//   write BusDriver enable for exactly one cycle. Read data is captured into a
//   shared register and flagged to the winner with a one-cycle rvalid pulse.
//   A requester holding lock can keep the grant for up to MAX_BURST
//   back-to-back accesses, one per cycle.
//
// Ports:
//   clock         system clock, all state updates on posedge
//   reset_L       asynchronous active-low reset
//   req           level request per requester
//   lock          requester asks to keep the grant for its next access
//   we_req        1 = write, 0 = read, per requester
//   addr_req      flattened addresses, requester i at [i*AW +: AW]
//   wdata_req     flattened write data, requester i at [i*DW +: DW]
//   gnt           one-hot, high during the ACCESS cycle serving requester i
//   rvalid        one-hot single-cycle pulse, read data ready for requester i
//   rdata         registered read data shared by all requesters
//   mem_re        Memory read enable
//   mem_we        Memory write enable
//   mem_addr      Memory address
//   mem_wdata     data to the write BusDriver
//   mem_drive_en  write BusDriver enable
//   mem_rdata     Memory data bus as seen through the BusDriver buffer
//   busy          high whenever an access is in progress
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int NREQ      = 4,
  parameter int DW        = 16,
  parameter int AW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic               clock,
  input  logic               reset_L,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    lock,
  input  logic [NREQ-1:0]    we_req,
  input  logic [NREQ*AW-1:0] addr_req,
  input  logic [NREQ*DW-1:0] wdata_req,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    rvalid,
  output logic [DW-1:0]      rdata,
  output logic               mem_re,
  output logic               mem_we,
  output logic [AW-1:0]      mem_addr,
  output logic [DW-1:0]      mem_wdata,
  output logic               mem_drive_en,
  input  logic [DW-1:0]      mem_rdata,
  output logic               busy
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BCW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;

  logic [0:0]      state_q,     state_d;
  logic [IDW-1:0]  ptr_q,       ptr_d;
  logic [BCW-1:0]  burst_cnt_q, burst_cnt_d;
  logic [IDW-1:0]  id_q,        id_d;
  logic            we_q,        we_d;
  logic [AW-1:0]   addr_q,      addr_d;
  logic [DW-1:0]   wdata_q,     wdata_d;
  logic [NREQ-1:0] rvalid_q,    rvalid_d;
  logic [DW-1:0]   rdata_q,     rdata_d;

  logic            win_found;
  logic [IDW-1:0]  win_id;
  logic            cont_burst;

  // Round-robin search: the first requesting index starting at ptr and
  // wrapping modulo NREQ. ptr always points one past the last owner, so the
  // previous owner ends up with the lowest priority.
  always_comb begin
    int cand;
    win_found = 1'b0;
    win_id    = '0;
    cand      = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= NREQ) begin
        cand = cand - NREQ;
      end
      if (!win_found && req[IDW'(cand)]) begin
        win_found = 1'b1;
        win_id    = IDW'(cand);
      end
    end
  end

  // The owner keeps the grant only while it still locks and requests, and
  // only until the burst reaches MAX_BURST accesses in total.
  always_comb begin
    cont_burst = lock[id_q] & req[id_q] &
                 (int'(burst_cnt_q) < (MAX_BURST - 1));
  end

  // Next-state logic. Each ACCESS cycle completes one memory operation at the
  // edge that ends it; a read is captured here and flagged for one cycle.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    burst_cnt_d = burst_cnt_q;
    id_d        = id_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rvalid_d    = '0;
    rdata_d     = rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d     = ST_ACCESS;
          id_d        = win_id;
          we_d        = we_req[win_id];
          addr_d      = addr_req[win_id*AW +: AW];
          wdata_d     = wdata_req[win_id*DW +: DW];
          burst_cnt_d = '0;
        end
      end

      ST_ACCESS: begin
        if (!we_q) begin
          rdata_d        = mem_rdata;
          rvalid_d[id_q] = 1'b1;
        end
        if (cont_burst) begin
          // Owner's operands are re-sampled so it may change address and
          // direction on every beat of the burst.
          we_d        = we_req[id_q];
          addr_d      = addr_req[id_q*AW +: AW];
          wdata_d     = wdata_req[id_q*DW +: DW];
          burst_cnt_d = burst_cnt_q + 1'b1;
        end else begin
          state_d = ST_IDLE;
          if (int'(id_q) == NREQ - 1) begin
            ptr_d = '0;
          end else begin
            ptr_d = id_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset returns every output source to zero at once.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      burst_cnt_q <= '0;
      id_q        <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rvalid_q    <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      burst_cnt_q <= burst_cnt_d;
      id_q        <= id_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
    end
  end

  // Memory-side drive is decoded purely from registered state, so the
  // enables are glitch-free and all drop together when reset clears state.
  // A read never enables the write BusDriver, keeping the bus uncontended.
  always_comb begin
    gnt          = '0;
    busy         = 1'b0;
    mem_re       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_drive_en = 1'b0;
    if (state_q == ST_ACCESS) begin
      gnt[id_q] = 1'b1;
      busy      = 1'b1;
      mem_addr  = addr_q;
      if (we_q) begin
        mem_we       = 1'b1;
        mem_drive_en = 1'b1;
        mem_wdata    = wdata_q;
      end else begin
        mem_re = 1'b1;
      end
    end
  end

  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios followed by randomized
// traffic, all checked cycle by cycle against a transaction-level model.
module tb_mem_arbiter;

   localparam int NREQ      = 4;
   localparam int DW        = 16;
   localparam int AW        = 8;
   localparam int MAX_BURST = 4;

   logic                clock;
   logic                reset_L;
   logic [NREQ-1:0]     reqV;
   logic [NREQ-1:0]     lockV;
   logic [NREQ-1:0]     weV;
   logic [NREQ*AW-1:0]  addrV;
   logic [NREQ*DW-1:0]  wdataV;
   logic [NREQ-1:0]     gnt;
   logic [NREQ-1:0]     rvalid;
   logic [DW-1:0]       rdata;
   logic                memRe;
   logic                memWe;
   logic [AW-1:0]       memAddr;
   logic [DW-1:0]       memWdata;
   logic                memDriveEn;
   logic [DW-1:0]       memRdata;
   logic                busy;

   logic [DW-1:0]       mem [0:255];
   logic                preEn;
   logic [AW-1:0]       preAddr;
   logic [DW-1:0]       preData;

   logic [DW-1:0]       refMem [0:255];
   int                  mOwner;
   int                  mPtr;
   int                  mCnt;
   bit                  mWe;
   int                  mAddr;
   logic [DW-1:0]       mWdata;
   int                  mRv;
   logic [DW-1:0]       mRdata;

   int                  checkCount;
   int                  passCount;

   mem_arbiter #(
      .NREQ(NREQ), .DW(DW), .AW(AW), .MAX_BURST(MAX_BURST)
   ) dut (
      .clock(clock),
      .reset_L(reset_L),
      .req(reqV),
      .lock(lockV),
      .we_req(weV),
      .addr_req(addrV),
      .wdata_req(wdataV),
      .gnt(gnt),
      .rvalid(rvalid),
      .rdata(rdata),
      .mem_re(memRe),
      .mem_we(memWe),
      .mem_addr(memAddr),
      .mem_wdata(memWdata),
      .mem_drive_en(memDriveEn),
      .mem_rdata(memRdata),
      .busy(busy)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Single-port Memory: combinational read, write committed on the clock
   // edge; the preload port is only used while the arbiter is held in reset.
   assign memRdata = mem[memAddr];

   always @(posedge clock) begin
      if (preEn) begin
         mem[preAddr] <= preData;
      end else if (memWe && memDriveEn) begin
         mem[memAddr] <= memWdata;
      end
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end else begin
         passCount++;
      end
   endtask

   task automatic applyStimulus(input int r, input bit rq, input bit lk, input bit w,
                                input logic [AW-1:0] a, input logic [DW-1:0] d);
      reqV[r]            = rq;
      lockV[r]           = lk;
      weV[r]             = w;
      addrV[r*AW +: AW]  = a;
      wdataV[r*DW +: DW] = d;
   endtask

   // Reference model: an owner index (or -1), the rotating priority start,
   // the beats already taken in the current burst and the latched operation.
   function automatic int pickWinner();
      int c;
      for (int k = 0; k < NREQ; k++) begin
         c = (mPtr + k) % NREQ;
         if (reqV[c]) return c;
      end
      return -1;
   endfunction

   task automatic modelReset();
      mOwner = -1;
      mPtr   = 0;
      mCnt   = 0;
      mWe    = 1'b0;
      mAddr  = 0;
      mWdata = '0;
      mRv    = -1;
      mRdata = '0;
   endtask

   task automatic modelLatch(input int r);
      mWe    = weV[r];
      mAddr  = int'(addrV[r*AW +: AW]);
      mWdata = wdataV[r*DW +: DW];
   endtask

   task automatic modelEdge();
      int newRv;
      newRv = -1;
      if (mOwner >= 0) begin
         if (!mWe) begin
            mRdata = refMem[mAddr];
            newRv  = mOwner;
         end else begin
            refMem[mAddr] = mWdata;
         end
         if (lockV[mOwner] && reqV[mOwner] && (mCnt + 1 < MAX_BURST)) begin
            mCnt = mCnt + 1;
            modelLatch(mOwner);
         end else begin
            mPtr   = (mOwner + 1) % NREQ;
            mOwner = -1;
         end
      end else if (reqV != '0) begin
         mOwner = pickWinner();
         mCnt   = 0;
         modelLatch(mOwner);
      end
      mRv = newRv;
   endtask

   task automatic compareAll();
      logic [NREQ-1:0] expGnt;
      logic [NREQ-1:0] expRv;
      bit              act;
      act    = (mOwner >= 0);
      expGnt = act ? NREQ'(1 << mOwner) : '0;
      expRv  = (mRv >= 0) ? NREQ'(1 << mRv) : '0;
      checkOutput("gnt",       64'(gnt),        64'(expGnt));
      checkOutput("rvalid",    64'(rvalid),     64'(expRv));
      checkOutput("rdata",     64'(rdata),      64'(mRdata));
      checkOutput("busy",      64'(busy),       64'(act));
      checkOutput("mem_re",    64'(memRe),      64'(act && !mWe));
      checkOutput("mem_we",    64'(memWe),      64'(act && mWe));
      checkOutput("drive_en",  64'(memDriveEn), 64'(act && mWe));
      checkOutput("mem_addr",  64'(memAddr),    act ? 64'(mAddr) : 64'd0);
      checkOutput("mem_wdata", 64'(memWdata),   (act && mWe) ? 64'(mWdata) : 64'd0);
      checkOutput("re_and_drive", 64'(memRe & memDriveEn), 64'd0);
   endtask

   task automatic stepCycle();
      @(posedge clock);
      modelEdge();
      @(negedge clock);
      compareAll();
   endtask

   task automatic resetDut(input bit doPreload);
      reset_L = 1'b0;
      reqV    = '0;
      lockV   = '0;
      weV     = '0;
      addrV   = '0;
      wdataV  = '0;
      modelReset();
      @(negedge clock);
      if (doPreload) begin
         for (int a = 0; a < 64; a++) begin
            preAddr   = AW'(a);
            preData   = (a == 16) ? 16'hBEEF : DW'($urandom);
            refMem[a] = preData;
            preEn     = 1'b1;
            @(negedge clock);
         end
         preEn = 1'b0;
      end
      compareAll();
      reset_L = 1'b1;
   endtask

   initial begin
      logic [NREQ-1:0] rrOrder [0:8];
      logic [NREQ-1:0] burstOrder [0:5];

      checkCount = 0;
      passCount  = 0;
      preEn      = 1'b0;
      preAddr    = '0;
      preData    = '0;
      for (int a = 0; a < 256; a++) begin
         refMem[a] = '0;
      end
      rrOrder    = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                     4'b0000, 4'b1000, 4'b0000, 4'b0001};
      burstOrder = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0100};

      resetDut(1'b1);

      $display("[TB] single read");
      applyStimulus(0, 1'b1, 1'b0, 1'b0, 8'h10, 16'h0000);
      stepCycle();
      checkOutput("t1_gnt", 64'(gnt), 64'h1);
      checkOutput("t1_addr", 64'(memAddr), 64'h10);
      reqV = '0;
      stepCycle();
      checkOutput("t1_rvalid", 64'(rvalid), 64'h1);
      checkOutput("t1_rdata", 64'(rdata), 64'hBEEF);

      $display("[TB] write then read");
      applyStimulus(1, 1'b1, 1'b0, 1'b1, 8'h22, 16'h1234);
      stepCycle();
      checkOutput("t2_we", 64'({gnt, memWe, memDriveEn}), 64'({4'b0010, 1'b1, 1'b1}));
      reqV = '0;
      stepCycle();
      applyStimulus(1, 1'b1, 1'b0, 1'b0, 8'h22, 16'h0000);
      stepCycle();
      reqV = '0;
      stepCycle();
      checkOutput("t2_rvalid", 64'(rvalid), 64'h2);
      checkOutput("t2_rdata", 64'(rdata), 64'h1234);

      $display("[TB] round robin");
      resetDut(1'b0);
      for (int r = 0; r < NREQ; r++) begin
         applyStimulus(r, 1'b1, 1'b0, 1'b0, AW'(r + 1), 16'h0000);
      end
      for (int i = 0; i < 9; i++) begin
         stepCycle();
         checkOutput($sformatf("t3_gnt%0d", i), 64'(gnt), 64'(rrOrder[i]));
      end

      $display("[TB] lock burst");
      resetDut(1'b0);
      applyStimulus(0, 1'b1, 1'b1, 1'b0, 8'h30, 16'h0000);
      applyStimulus(2, 1'b1, 1'b0, 1'b0, 8'h08, 16'h0000);
      for (int i = 0; i < 6; i++) begin
         stepCycle();
         checkOutput($sformatf("t4_gnt%0d", i), 64'(gnt), 64'(burstOrder[i]));
         addrV[0 +: AW] = AW'(8'h31 + i);
         if (i == 4) reqV[0] = 1'b0;
      end
      reqV  = '0;
      lockV = '0;
      stepCycle();
      stepCycle();

      $display("[TB] early release");
      resetDut(1'b0);
      applyStimulus(3, 1'b1, 1'b1, 1'b0, 8'h03, 16'h0000);
      stepCycle();
      addrV[3*AW +: AW] = 8'h04;
      stepCycle();
      checkOutput("t5_gnt", 64'(gnt), 64'h8);
      reqV[3] = 1'b0;
      stepCycle();
      checkOutput("t5_busy", 64'(busy), 64'h0);
      lockV = '0;
      applyStimulus(0, 1'b1, 1'b0, 1'b0, 8'h01, 16'h0000);
      applyStimulus(3, 1'b1, 1'b0, 1'b0, 8'h02, 16'h0000);
      stepCycle();
      checkOutput("t5_ptr0", 64'(gnt), 64'h1);
      reqV = '0;
      stepCycle();
      stepCycle();

      $display("[TB] reset mid access");
      resetDut(1'b0);
      applyStimulus(2, 1'b1, 1'b0, 1'b0, 8'h05, 16'h0000);
      stepCycle();
      reqV = '0;
      stepCycle();
      reqV[2] = 1'b1;
      stepCycle();
      checkOutput("t6_pre", 64'(gnt), 64'h4);
      reset_L = 1'b0;
      reqV    = '0;
      #1;
      checkOutput("t6_gnt", 64'(gnt), 64'h0);
      checkOutput("t6_re", 64'(memRe), 64'h0);
      checkOutput("t6_busy", 64'(busy), 64'h0);
      modelReset();
      @(posedge clock);
      @(negedge clock);
      checkOutput("t6_rvalid", 64'(rvalid), 64'h0);
      reset_L = 1'b1;
      applyStimulus(1, 1'b1, 1'b0, 1'b0, 8'h06, 16'h0000);
      applyStimulus(3, 1'b1, 1'b0, 1'b0, 8'h07, 16'h0000);
      stepCycle();
      checkOutput("t6_after", 64'(gnt), 64'h2);
      reqV = '0;
      stepCycle();
      stepCycle();

      $display("[TB] random traffic");
      for (int i = 0; i < 400; i++) begin
         for (int r = 0; r < NREQ; r++) begin
            applyStimulus(r, 1'($urandom), 1'($urandom & $urandom), 1'($urandom),
                          AW'($urandom_range(0, 63)), DW'($urandom));
         end
         stepCycle();
      end
      reqV  = '0;
      lockV = '0;
      stepCycle();
      stepCycle();

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
